// File: rtl/roll_rx_arbiter.sv
// Round-robin arbiter that shares one serial roll receiver between NUM_REQ requesters.
// Grants one requester, pulses the receiver start, waits for valid or a timeout, then returns the roll.
module roll_rx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_busy,
    output logic               o_rx_start,
    input  logic               i_rx_valid,
    input  logic [6:0]         i_rx_data,
    output logic [6:0]         o_data,
    output logic [NUM_REQ-1:0] o_done,
    output logic               o_timeout
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   pick_c;
    logic               found_c;
    logic [NUM_REQ-1:0] grant_d, done_d;
    logic               busy_d, start_d, timeout_d;
    logic [6:0]         data_d;

    // First active request at or above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        pick_c  = '0;
        found_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found_c && i_req[PTR_W'(idx)]) begin
                found_c = 1'b1;
                pick_c  = PTR_W'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        grant_d   = o_grant;
        data_d    = o_data;
        start_d   = 1'b0;
        done_d    = '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    sel_d   = pick_c;
                    grant_d = NUM_REQ'(1) << pick_c;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (i_rx_valid) begin
                    data_d  = i_rx_data;
                    done_d  = o_grant;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d    = '0;
                    done_d    = o_grant;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                grant_d = '0;
                ptr_d   = (sel_q == PTR_LAST) ? '0 : sel_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            o_rx_start <= 1'b0;
            o_data     <= '0;
            o_done     <= '0;
            o_timeout  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            o_grant    <= grant_d;
            o_busy     <= busy_d;
            o_rx_start <= start_d;
            o_data     <= data_d;
            o_done     <= done_d;
            o_timeout  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_roll_rx_arbiter.sv
// Bench for roll_rx_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_roll_rx_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] i_req;
    logic [NREQ-1:0] o_grant;
    logic            o_busy;
    logic            o_rx_start;
    logic            i_rx_valid;
    logic [6:0]      i_rx_data;
    logic [6:0]      o_data;
    logic [NREQ-1:0] o_done;
    logic            o_timeout;

    roll_rx_arbiter #(
        .NUM_REQ       (NREQ),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_rx_start(o_rx_start),
        .i_rx_valid(i_rx_valid),
        .i_rx_data (i_rx_data),
        .o_data    (o_data),
        .o_done    (o_done),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a transaction is active from grant until its done cycle ends.
    // m_age counts WAIT cycles (0 = the start cycle); m_fin marks the done cycle.
    bit         m_act = 1'b0;
    bit         m_fin = 1'b0;
    bit         m_to  = 1'b0;
    bit         m_found;
    int         m_ptr = 0;
    int         m_sel = 0;
    int         m_age = 0;
    int         m_idx;
    logic [6:0] m_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_act = 1'b0; m_fin = 1'b0; m_to = 1'b0;
            m_ptr = 0; m_age = 0; m_data = '0;
        end else if (!m_act) begin
            m_found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                m_idx = (m_ptr + k) % NREQ;
                if (!m_found && i_req[m_idx[1:0]]) begin
                    m_found = 1'b1;
                    m_sel   = m_idx;
                end
            end
            if (m_found) begin
                m_act = 1'b1; m_age = 0; m_fin = 1'b0; m_to = 1'b0;
            end
        end else if (m_fin) begin
            m_act = 1'b0; m_fin = 1'b0; m_to = 1'b0;
            m_ptr = (m_sel + 1) % NREQ;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (i_rx_valid) begin
            m_data = i_rx_data; m_fin = 1'b1; m_to = 1'b0;
        end else if (m_age == TO) begin
            m_data = '0; m_fin = 1'b1; m_to = 1'b1;
        end else begin
            m_age++;
        end
    end

    logic [NREQ-1:0] e_grant, e_done;

    always @(negedge clk) begin
        if (chk_en) begin
            e_grant = m_act ? (NREQ'(1) << m_sel) : '0;
            e_done  = (m_act && m_fin) ? (NREQ'(1) << m_sel) : '0;
            chk("grant",   32'(o_grant),    32'(e_grant));
            chk("busy",    32'(o_busy),     32'(m_act));
            chk("start",   32'(o_rx_start), 32'(m_act && !m_fin && m_age == 0));
            chk("done",    32'(o_done),     32'(e_done));
            chk("timeout", 32'(o_timeout),  32'(m_act && m_fin && m_to));
            chk("data",    32'(o_data),     32'(m_data));
        end
    end

    // One transaction starting from an IDLE-cycle negedge; returns at the done-cycle negedge.
    task automatic txn(input logic [NREQ-1:0] req, input int wn, input bit vld,
                       input logic [6:0] d, input bit drop);
        i_req = req;
        @(negedge clk);
        if (drop) i_req = '0;
        repeat (wn) @(negedge clk);
        i_rx_valid = vld;
        i_rx_data  = d;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    logic [NREQ-1:0] rr_seen[5];
    logic [NREQ-1:0] rr_exp[5];
    logic [NREQ-1:0] mask;
    int              wn;
    bit              vld;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1; i_req = '0; i_rx_valid = 1'b0; i_rx_data = '0;
        @(negedge clk);
        chk("rst_grant",   32'(o_grant),    32'h0);
        chk("rst_busy",    32'(o_busy),     32'h0);
        chk("rst_start",   32'(o_rx_start), 32'h0);
        chk("rst_done",    32'(o_done),     32'h0);
        chk("rst_timeout", 32'(o_timeout),  32'h0);
        chk("rst_data",    32'(o_data),     32'h0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Round robin with all requests held
        for (int r = 0; r < 5; r++) begin
            txn(4'b1111, 3, 1'b1, 7'(r * 9 + 1), 1'b0);
            rr_seen[r] = o_done;
            if (r == 4) i_req = '0;
            @(negedge clk);
            chk("rr_idle_gap", 32'(o_grant), 32'h0);
        end
        for (int r = 0; r < 5; r++) chk("rr_order", 32'(rr_seen[r]), 32'(rr_exp[r]));

        // Single requester
        i_req = 4'b0100;
        @(negedge clk);
        chk("single_grant", 32'(o_grant),    32'h4);
        chk("single_start", 32'(o_rx_start), 32'h1);
        repeat (5) @(negedge clk);
        i_rx_valid = 1'b1; i_rx_data = 7'h2A;
        @(negedge clk);
        i_rx_valid = 1'b0; i_req = '0;
        chk("single_done",    32'(o_done),    32'h4);
        chk("single_data",    32'(o_data),    32'h2A);
        chk("single_timeout", 32'(o_timeout), 32'h0);
        @(negedge clk);
        chk("single_release", 32'(o_grant), 32'h0);

        // Timeout after TO wait cycles
        txn(4'b0001, TO, 1'b0, 7'h55, 1'b0);
        i_req = '0;
        chk("to_done", 32'(o_done),    32'h1);
        chk("to_flag", 32'(o_timeout), 32'h1);
        chk("to_data", 32'(o_data),    32'h0);
        @(negedge clk);

        // Valid on the last wait cycle wins over timeout
        txn(4'b0001, TO, 1'b1, 7'h05, 1'b0);
        i_req = '0;
        chk("edge_done",    32'(o_done),    32'h1);
        chk("edge_timeout", 32'(o_timeout), 32'h0);
        chk("edge_data",    32'(o_data),    32'h05);
        @(negedge clk);

        // Reset during WAIT, then pointer back at 0
        i_req = 4'b1000;
        repeat (3) @(negedge clk);
        reset = 1'b1; i_req = '0;
        @(negedge clk);
        chk("mid_rst_grant", 32'(o_grant), 32'h0);
        chk("mid_rst_busy",  32'(o_busy),  32'h0);
        chk("mid_rst_done",  32'(o_done),  32'h0);
        chk("mid_rst_data",  32'(o_data),  32'h0);
        reset = 1'b0;
        @(negedge clk);
        txn(4'b1001, 2, 1'b1, 7'h11, 1'b0);
        i_req = '0;
        chk("post_rst_done", 32'(o_done), 32'h1);
        @(negedge clk);

        // Stray valid while idle, then a requester that drops its request
        i_rx_valid = 1'b1; i_rx_data = 7'h7F;
        @(negedge clk);
        i_rx_valid = 1'b0;
        chk("stray_data", 32'(o_data), 32'h11);
        chk("stray_busy", 32'(o_busy), 32'h0);
        txn(4'b0100, 3, 1'b1, 7'h33, 1'b1);
        chk("drop_done", 32'(o_done), 32'h4);
        chk("drop_data", 32'(o_data), 32'h33);
        @(negedge clk);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            mask = NREQ'($urandom_range(0, 15));
            if (mask == '0) begin
                i_req      = '0;
                i_rx_valid = 1'($urandom_range(0, 1));
                i_rx_data  = 7'($urandom_range(0, 127));
                @(negedge clk);
                i_rx_valid = 1'b0;
            end else begin
                vld = ($urandom_range(0, 3) != 0);
                wn  = vld ? int'($urandom_range(1, TO)) : TO;
                txn(mask, wn, vld, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 0) i_req = '0;
                @(negedge clk);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/roll_rx_arbiter.md
Name: roll_rx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single serial-to-parallel roll receiver between NUM_REQ dice-logic requesters.
- Grants one requester at a time, pulses the receiver start, waits for the receiver's valid with a timeout, then returns the 7-bit roll value to the granted requester with a one-hot done pulse.
- Sits between the per-die control logic and the serial receiver.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 1024, WAIT cycles before abandoning a transaction; legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  NUM_REQ  per-requester level request.
- o_grant  output  NUM_REQ  one-hot grant; held for the whole transaction.
- o_busy  output  1  high whenever state != IDLE.
- o_rx_start  output  1  one-cycle start pulse to the serial receiver.
- i_rx_valid  input  1  receiver data-valid.
- i_rx_data  input  7  receiver parallel data.
- o_data  output  7  captured roll value; holds until the next capture or timeout.
- o_done  output  NUM_REQ  one-cycle one-hot completion pulse to the granted requester.
- o_timeout  output  1  one-cycle pulse, coincident with o_done, when the transaction timed out.

Behaviour:
- Clock, reset and ports: one clock `clk`; reset is synchronous and active-high, port `reset`. All outputs are registered.
- Reset values:
  - o_grant=0, o_busy=0, o_rx_start=0, o_data=0, o_done=0, o_timeout=0.
  - State=IDLE, RR pointer=0, timeout counter (16 bit)=0.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - If i_req != 0, select the first set bit searching upward from the RR pointer with wrap-around (index ptr, ptr+1, ..., NUM_REQ-1, 0, ...).
  - At the edge: o_grant<=onehot(sel), o_rx_start<=1, state<=START.
  - If i_req==0, stay in IDLE.
- START: lasts exactly one cycle (o_rx_start high during it). At the edge: o_rx_start<=0, counter<=0, state<=WAIT.
- WAIT:
  - If i_rx_valid: o_data<=i_rx_data, o_done<=o_grant, o_timeout<=0, state<=DONE.
  - Else if counter==TIMEOUT_CYCLES-1: o_data<=0, o_done<=o_grant, o_timeout<=1, state<=DONE.
  - Else counter<=counter+1.
  - Valid and timeout in the same cycle: valid wins, no timeout.
- DONE:
  - Lasts one cycle with o_done (and o_timeout if set) high.
  - At the edge: o_done<=0, o_timeout<=0, o_grant<=0, RR pointer<=(sel+1) mod NUM_REQ, state<=IDLE.
- Latency:
  - Req seen in IDLE at cycle N gives grant and start visible at N+1.
  - Valid sampled at cycle M gives o_done and o_data at M+1.
  - Grant drops at M+2.
  - Back-to-back requests: the next grant appears at M+3 (one IDLE cycle minimum).
- Requests:
  - Deassertion of i_req by the granted requester mid-transaction is ignored; the transaction completes and done still pulses.
  - Requests from others are only evaluated in IDLE.
- i_rx_valid outside WAIT is ignored; o_data is unchanged.
- Fairness: a continuously asserted requester cannot be granted twice while another requester is waiting.
- Reset mid-operation: everything returns to reset values on the next edge, with no done pulse. Receiver cleanup is the receiver's own reset.
- Invariants: o_grant and o_done are never multi-hot. o_rx_start is exactly one pulse per grant.

Test Plan:
- Single requester: NUM_REQ=4, i_req=4'b0100, receiver returns valid with data 7'h2A after 9 cycles.
  - Response: o_grant=4'b0100 one cycle after req; one o_rx_start pulse; o_done=4'b0100 and o_data=7'h2A one cycle after valid; o_timeout=0; grant clears the next cycle.
- Round robin: i_req=4'b1111 held, each transaction returns valid.
  - Response: grant sequence 0001, 0010, 0100, 1000, 0001, with exactly 1 IDLE cycle between transactions.
- Timeout: TIMEOUT_CYCLES=8, i_req=4'b0001, valid never asserted.
  - Response: o_done=0001 and o_timeout=1 exactly 8 WAIT cycles after START; o_data=0.
- Valid on the boundary: TIMEOUT_CYCLES=8, valid asserted on the 8th WAIT cycle with data 7'h05.
  - Response: o_timeout=0, o_data=7'h05.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT.
  - Response: all outputs 0 next cycle, no o_done pulse; the next i_req=4'b0010 is granted with RR pointer 0 semantics.
- Request drop and stray valid: requester drops i_req after grant, and i_rx_valid=1 while IDLE with data 7'h7F.
  - Response: the transaction still completes with o_done pulse; the IDLE valid is ignored and o_data is unchanged.
